// File: rtl/cnn_reg_pkg.sv
// CNN register map shared by the configuration master and the CNN subordinate.
package cnn_reg_pkg;

    localparam logic [31:0] CtrlOff       = 32'h00;
    localparam logic [31:0] StatusOff     = 32'h04;
    localparam logic [31:0] InputBaseOff  = 32'h08;
    localparam logic [31:0] OutputBaseOff = 32'h0C;
    localparam logic [31:0] WeightBaseOff = 32'h10;
    localparam int unsigned NumWeights    = 9;
    localparam int unsigned NumWrites     = NumWeights + 3;
    localparam int unsigned WidxW         = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        POLL_REQ,
        POLL_RSP,
        POLL_WAIT,
        DONE,
        ERR
    } cfg_state_e;

endpackage

// File: rtl/obi_pkg.sv
// Minimal OBI bus definitions: configuration record and default request/response channel structs.
package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic        user;
        logic [1:0]  region;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_rsp_t;

endpackage

// File: rtl/cnn_cfg_seq_rom.sv
// Maps the configuration write index to the {addr, wdata} pair of that write:
// weights first, then input base, output base and finally the CTRL start bit.
module cnn_cfg_seq_rom
    import cnn_reg_pkg::*;
#(
    parameter logic [31:0] CnnBase = 32'h2000_0000
) (
    input  logic [WidxW-1:0] widx_i,
    input  logic [31:0]      input_base_i,
    input  logic [31:0]      output_base_i,
    input  logic [71:0]      weights_i,
    output logic [31:0]      addr_o,
    output logic [31:0]      wdata_o
);

    logic [NumWeights-1:0][7:0] w_arr;
    logic [7:0]                 w_sel;

    assign w_arr = weights_i;

    always_comb begin
        addr_o  = '0;
        wdata_o = '0;
        w_sel   = '0;
        if (widx_i < WidxW'(NumWeights)) begin
            w_sel   = w_arr[widx_i];
            addr_o  = CnnBase + WeightBaseOff + (32'(widx_i) << 2);
            wdata_o = {{24{w_sel[7]}}, w_sel};
        end else if (widx_i == WidxW'(NumWeights)) begin
            addr_o  = CnnBase + InputBaseOff;
            wdata_o = input_base_i;
        end else if (widx_i == WidxW'(NumWeights + 1)) begin
            addr_o  = CnnBase + OutputBaseOff;
            wdata_o = output_base_i;
        end else if (widx_i == WidxW'(NumWeights + 2)) begin
            addr_o  = CnnBase + CtrlOff;
            wdata_o = 32'h1;
        end
    end

endmodule

// File: rtl/cnn_cfg_master.sv
// OBI manager that programs the CNN register window (weights, buffers, start)
// and then polls STATUS until the accelerator reports completion or a timeout.
module cnn_cfg_master
    import cnn_reg_pkg::*;
#(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter logic [31:0]       CnnBase   = 32'h2000_0000,
    parameter int unsigned       PollLimit = 1024,
    parameter int unsigned       PollGap   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] input_base_i,
    input  logic [31:0] output_base_i,
    input  logic [71:0] weights_i,
    output obi_req_t    mgr_obi_req_o,
    input  obi_rsp_t    mgr_obi_rsp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned AddrW = ObiCfg.AddrWidth;
    localparam int unsigned PollW = $clog2(PollLimit + 1);
    localparam int unsigned GapW  = (PollGap > 1) ? $clog2(PollGap) : 1;

    cfg_state_e       state_q, state_d;
    logic [WidxW-1:0] widx_q, widx_d;
    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0]      in_base_q, in_base_d;
    logic [31:0]      out_base_q, out_base_d;
    logic [71:0]      weights_q, weights_d;
    logic [31:0]      rom_addr, rom_wdata;
    logic             unused_rsp;

    assign unused_rsp = ^{mgr_obi_rsp_i.r.rdata[31:1], mgr_obi_rsp_i.r.rid};

    cnn_cfg_seq_rom #(
        .CnnBase(CnnBase)
    ) u_seq_rom (
        .widx_i       (widx_q),
        .input_base_i (in_base_q),
        .output_base_i(out_base_q),
        .weights_i    (weights_q),
        .addr_o       (rom_addr),
        .wdata_o      (rom_wdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            widx_q     <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            weights_q  <= '0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            weights_q  <= weights_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        poll_cnt_d    = poll_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        in_base_d     = in_base_q;
        out_base_d    = out_base_q;
        weights_d     = weights_q;
        mgr_obi_req_o = '0;
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == DONE);
        err_o         = (state_q == ERR);

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    in_base_d  = input_base_i;
                    out_base_d = output_base_i;
                    weights_d  = weights_i;
                    widx_d     = '0;
                    poll_cnt_d = '0;
                    state_d    = WR_REQ;
                end
            end
            WR_REQ: begin
                mgr_obi_req_o.req     = 1'b1;
                mgr_obi_req_o.a.we    = 1'b1;
                mgr_obi_req_o.a.be    = 4'hF;
                mgr_obi_req_o.a.addr  = rom_addr[AddrW-1:0];
                mgr_obi_req_o.a.wdata = rom_wdata;
                if (mgr_obi_rsp_i.gnt) state_d = WR_RSP;
            end
            WR_RSP: begin
                if (mgr_obi_rsp_i.rvalid) begin
                    if (mgr_obi_rsp_i.r.err) begin
                        state_d = ERR;
                    end else if (widx_q == WidxW'(NumWrites - 1)) begin
                        state_d = POLL_REQ;
                    end else begin
                        widx_d  = widx_q + WidxW'(1);
                        state_d = WR_REQ;
                    end
                end
            end
            POLL_REQ: begin
                mgr_obi_req_o.req    = 1'b1;
                mgr_obi_req_o.a.be   = 4'hF;
                mgr_obi_req_o.a.addr = CnnBase + StatusOff;
                if (mgr_obi_rsp_i.gnt) state_d = POLL_RSP;
            end
            POLL_RSP: begin
                // The timeout compares the count including this read, so ERR
                // follows the PollLimit-th zero STATUS without another wait.
                if (mgr_obi_rsp_i.rvalid) begin
                    poll_cnt_d = poll_cnt_q + PollW'(1);
                    if (mgr_obi_rsp_i.r.err) begin
                        state_d = ERR;
                    end else if (mgr_obi_rsp_i.r.rdata[0]) begin
                        state_d = DONE;
                    end else if (32'(poll_cnt_q) + 32'd1 >= PollLimit) begin
                        state_d = ERR;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = POLL_WAIT;
                    end
                end
            end
            POLL_WAIT: begin
                gap_cnt_d = gap_cnt_q + GapW'(1);
                if (32'(gap_cnt_q) + 32'd1 >= PollGap) state_d = POLL_REQ;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
